// File: rtl/seq_alu.sv
// Registered ALU: single-cycle logic/add/sub/compare plus iterative unsigned
// multiply (radix-2 shift-add) and restoring divide behind a start/busy/done handshake.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             carryout,
    output logic             overflow,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    // Handshake: start is sampled only in IDLE; busy is high while iterating;
    // done pulses for exactly one cycle per accepted start, with outputs valid.
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIN = 2'd3} state_t;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_MULU = 3'b011;
    localparam logic [2:0] OP_DIVU = 3'b100;
    localparam logic [2:0] OP_SLTU = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] opd, hi, lo;
    logic             last_iter;

    logic             invert_b, cout, sum_v, alu_c, alu_o;
    logic [WIDTH-1:0] b_eff, sum, alu_res;

    logic [WIDTH:0]   mul_sum, div_shift, div_trial;
    logic [WIDTH-1:0] mul_hi_nxt, mul_lo_nxt, div_hi_nxt, div_lo_nxt;
    logic             div_ok;

    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    assign busy      = (state == MUL) || (state == DIV);
    assign dbg_state = state;

    // Single-cycle datapath: SUB/SLT/SLTU all use a + ~b + 1.
    always_comb begin
        invert_b    = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
        b_eff       = invert_b ? ~b : b;
        {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, invert_b};
        sum_v       = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        alu_res     = '0;
        alu_c       = 1'b0;
        alu_o       = 1'b0;
        case (op)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_ADD:  begin alu_res = sum; alu_c = cout;  alu_o = sum_v; end
            OP_SUB:  begin alu_res = sum; alu_c = ~cout; alu_o = sum_v; end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ sum_v};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, ~cout};
            default: ;
        endcase
    end

    // One iteration step of multiply ({hi,lo} shifts right) and divide ({hi,lo} shifts left).
    always_comb begin
        mul_sum    = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
        mul_hi_nxt = mul_sum[WIDTH:1];
        mul_lo_nxt = {mul_sum[0], lo[WIDTH-1:1]};
        div_shift  = {hi, lo[WIDTH-1]};
        div_trial  = div_shift - {1'b0, opd};
        div_ok     = ~div_trial[WIDTH];
        div_hi_nxt = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_lo_nxt = {lo[WIDTH-2:0], div_ok};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && op == OP_MULU)                 state_nxt = MUL;
                else if (start && op == OP_DIVU && b != '0) state_nxt = DIV;
            end
            MUL, DIV: if (last_iter) state_nxt = FIN;
            FIN:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // The last iteration writes the outputs directly so FIN is the done cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            opd         <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            result      <= '0;
            result_hi   <= '0;
            zero        <= 1'b0;
            carryout    <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op == OP_MULU) begin
                            opd <= a;
                            hi  <= '0;
                            lo  <= b;
                            cnt <= '0;
                        end else if (op == OP_DIVU && b != '0) begin
                            opd <= b;
                            hi  <= '0;
                            lo  <= a;
                            cnt <= '0;
                        end else if (op == OP_DIVU) begin
                            result      <= '1;
                            result_hi   <= a;
                            zero        <= 1'b0;
                            carryout    <= 1'b0;
                            overflow    <= 1'b0;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                        end else begin
                            result      <= alu_res;
                            result_hi   <= '0;
                            zero        <= (alu_res == '0);
                            carryout    <= alu_c;
                            overflow    <= alu_o;
                            div_by_zero <= 1'b0;
                            done        <= 1'b1;
                        end
                    end
                end
                MUL, DIV: begin
                    cnt <= cnt + 1'b1;
                    hi  <= (state == MUL) ? mul_hi_nxt : div_hi_nxt;
                    lo  <= (state == MUL) ? mul_lo_nxt : div_lo_nxt;
                    if (last_iter) begin
                        result      <= (state == MUL) ? mul_lo_nxt : div_lo_nxt;
                        result_hi   <= (state == MUL) ? mul_hi_nxt : div_hi_nxt;
                        zero        <= (((state == MUL) ? mul_lo_nxt : div_lo_nxt) == '0);
                        carryout    <= 1'b0;
                        overflow    <= 1'b0;
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed plan steps plus randomized ops on 32- and 8-bit
// instances, checked against an arithmetic reference model.
module tb_seq_alu;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_MULU = 3'b011;
    localparam logic [2:0] OP_DIVU = 3'b100;
    localparam logic [2:0] OP_SLTU = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef struct packed {
        logic [63:0] res;
        logic [63:0] hi;
        logic        z;
        logic        c;
        logic        v;
        logic        dz;
        logic        done;
        logic        busy;
        int          lat;
    } alu_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start32, busy32, done32, zero32, carry32, ovf32, dbz32;
    logic [2:0]  op32;
    logic [31:0] a32, b32, result32, result_hi32;
    logic [1:0]  dbg_state32;

    logic        start8, busy8, done8, zero8, carry8, ovf8, dbz8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, result8, result_hi8;
    logic [1:0]  dbg_state8;

    seq_alu #(.WIDTH(32), .CNT_W(6)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .op(op32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .result(result32), .result_hi(result_hi32),
        .zero(zero32), .carryout(carry32), .overflow(ovf32), .div_by_zero(dbz32),
        .dbg_state(dbg_state32)
    );

    seq_alu #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(result8), .result_hi(result_hi8),
        .zero(zero8), .carryout(carry8), .overflow(ovf8), .div_by_zero(dbz8),
        .dbg_state(dbg_state8)
    );

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation's meaning.
    function automatic alu_t model(input int w, input logic [2:0] o,
                                   input logic [63:0] x, input logic [63:0] y);
        alu_t        e;
        logic [63:0] m, p;
        longint      sx, sy, sr, smax, smin;
        e    = '0;
        e.lat = 1;
        m    = (64'd1 << w) - 64'd1;
        smax = (longint'(1) << (w - 1)) - 1;
        smin = -(longint'(1) << (w - 1));
        sx   = x[w-1] ? longint'(x) - (longint'(1) << w) : longint'(x);
        sy   = y[w-1] ? longint'(y) - (longint'(1) << w) : longint'(y);
        case (o)
            OP_AND: e.res = x & y;
            OP_OR:  e.res = x | y;
            OP_ADD: begin
                p     = x + y;
                e.res = p & m;
                e.c   = p[w];
                sr    = sx + sy;
                e.v   = (sr > smax) || (sr < smin);
            end
            OP_SUB: begin
                e.res = (x - y) & m;
                e.c   = (x < y);
                sr    = sx - sy;
                e.v   = (sr > smax) || (sr < smin);
            end
            OP_SLT:  e.res = {63'b0, (sx < sy)};
            OP_SLTU: e.res = {63'b0, (x < y)};
            OP_MULU: begin
                p     = x * y;
                e.res = p & m;
                e.hi  = (p >> w) & m;
                e.lat = w + 1;
            end
            default: begin
                if (y == 64'd0) begin
                    e.res = m;
                    e.hi  = x;
                    e.dz  = 1'b1;
                end else begin
                    e.res = x / y;
                    e.hi  = x % y;
                    e.lat = w + 1;
                end
            end
        endcase
        e.z = (e.res == 64'd0);
        return e;
    endfunction

    // driver tasks
    task automatic drive(input int w, input logic st, input logic [2:0] o,
                         input logic [63:0] x, input logic [63:0] y);
        if (w == 32) begin
            start32 = st; op32 = o; a32 = x[31:0]; b32 = y[31:0];
        end else begin
            start8 = st; op8 = o; a8 = x[7:0]; b8 = y[7:0];
        end
    endtask

    task automatic drive_idle_random(input int w);
        drive(w, 1'b0, 3'($urandom_range(0, 7)), {32'h0, $urandom}, {32'h0, $urandom});
    endtask

    task automatic sample(input int w, output alu_t s);
        s = '0;
        if (w == 32) begin
            s.res = {32'h0, result32}; s.hi = {32'h0, result_hi32};
            s.z = zero32; s.c = carry32; s.v = ovf32; s.dz = dbz32;
            s.done = done32; s.busy = busy32;
        end else begin
            s.res = {56'h0, result8}; s.hi = {56'h0, result_hi8};
            s.z = zero8; s.c = carry8; s.v = ovf8; s.dz = dbz8;
            s.done = done8; s.busy = busy8;
        end
    endtask

    // Issue one op, wait (bounded) for done, compare everything against the model.
    task automatic do_op(input int w, input logic [2:0] o, input logic [63:0] x,
                         input logic [63:0] y, input int inject_at, input string tag);
        alu_t e, s, s2;
        int   lat;
        bit   got, busy_ok;
        e = model(w, o, x, y);
        exp_q.push_back(e.res);
        exp_q.push_back(e.hi);
        @(negedge clk);
        drive(w, 1'b1, o, x, y);
        @(posedge clk);
        #1;
        drive_idle_random(w);
        lat = 0; got = 1'b0; busy_ok = 1'b1; s = '0;
        while (!got && lat < 300) begin
            @(negedge clk);
            lat++;
            sample(w, s);
            if (s.done) got = 1'b1;
            if (s.busy !== (e.lat > 1 && !got)) busy_ok = 1'b0;
            if (lat == inject_at) begin
                drive(w, 1'b1, OP_AND, {32'h0, $urandom}, {32'h0, $urandom});
                @(posedge clk);
                #1;
                drive_idle_random(w);
            end
        end
        check({tag, ".done_seen"}, 64'(got), 64'd1);
        check({tag, ".latency"}, 64'(lat), 64'(e.lat));
        check({tag, ".busy"}, 64'(busy_ok), 64'd1);
        check({tag, ".result"}, s.res, exp_q.pop_front());
        check({tag, ".result_hi"}, s.hi, exp_q.pop_front());
        check({tag, ".zero"}, 64'(s.z), 64'(e.z));
        check({tag, ".carryout"}, 64'(s.c), 64'(e.c));
        check({tag, ".overflow"}, 64'(s.v), 64'(e.v));
        check({tag, ".div_by_zero"}, 64'(s.dz), 64'(e.dz));
        @(negedge clk);
        sample(w, s2);
        check({tag, ".done_pulse"}, 64'(s2.done), 64'd0);
        check({tag, ".hold"}, s2.res, e.res);
    endtask

    initial begin
        alu_t e, s;
        drive(32, 1'b0, OP_AND, 64'd0, 64'd0);
        drive(8, 1'b0, OP_AND, 64'd0, 64'd0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.busy", 64'(busy32), 64'd0);
        check("rst.done", 64'(done32), 64'd0);
        check("rst.result", {32'h0, result32}, 64'd0);
        check("rst.result_hi", {32'h0, result_hi32}, 64'd0);
        check("rst.flags", {60'h0, zero32, carry32, ovf32, dbz32}, 64'd0);
        check("rst.state", 64'(dbg_state32), 64'd0);
        check("rst8.all", {38'h0, dbg_state8, busy8, done8, result8, result_hi8,
                           zero8, carry8, ovf8, dbz8}, 64'd0);
        rst_n = 1'b1;

        // 1: ADD signed overflow
        do_op(32, OP_ADD, 64'h7FFF_FFFF, 64'd1, 0, "t1_add");

        // 2: back-to-back single-cycle ops, start held through done cycles
        @(negedge clk);
        drive(32, 1'b1, OP_SUB, 64'd5, 64'd5);
        @(negedge clk);
        e = model(32, OP_SUB, 64'd5, 64'd5);
        sample(32, s);
        check("t2_sub.done", 64'(s.done), 64'd1);
        check("t2_sub.result", s.res, e.res);
        check("t2_sub.zero", 64'(s.z), 64'(e.z));
        check("t2_sub.carryout", 64'(s.c), 64'(e.c));
        drive(32, 1'b1, OP_SLT, 64'hFFFF_FFFF, 64'd1);
        @(negedge clk);
        e = model(32, OP_SLT, 64'hFFFF_FFFF, 64'd1);
        sample(32, s);
        check("t2_slt.done", 64'(s.done), 64'd1);
        check("t2_slt.result", s.res, e.res);
        drive(32, 1'b1, OP_SLTU, 64'hFFFF_FFFF, 64'd1);
        @(negedge clk);
        e = model(32, OP_SLTU, 64'hFFFF_FFFF, 64'd1);
        sample(32, s);
        check("t2_sltu.done", 64'(s.done), 64'd1);
        check("t2_sltu.result", s.res, e.res);
        drive(32, 1'b0, OP_AND, 64'd0, 64'd0);
        @(negedge clk);
        check("t2.done_drop", 64'(done32), 64'd0);

        // 3: MULU with an ignored start at cycle 10
        do_op(32, OP_MULU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 10, "t3_mulu");

        // 4: DIVU normal and divide-by-zero
        do_op(32, OP_DIVU, 64'd100, 64'd7, 0, "t4_divu");
        do_op(32, OP_DIVU, 64'd9, 64'd0, 0, "t4_div0");

        // 5: reset abort mid-multiply
        @(negedge clk);
        drive(32, 1'b1, OP_MULU, 64'h1234_5678, 64'h9ABC_DEF0);
        @(posedge clk);
        #1;
        drive(32, 1'b0, OP_AND, 64'd0, 64'd0);
        repeat (15) @(negedge clk);
        check("t5.busy_before", 64'(busy32), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t5.busy", 64'(busy32), 64'd0);
        check("t5.done", 64'(done32), 64'd0);
        check("t5.result", {32'h0, result32}, 64'd0);
        check("t5.result_hi", {32'h0, result_hi32}, 64'd0);
        check("t5.state", 64'(dbg_state32), 64'd0);
        repeat (2) @(negedge clk);
        check("t5.no_done", 64'(done32), 64'd0);
        rst_n = 1'b1;
        do_op(32, OP_AND, 64'hF0F0, 64'hFF00, 0, "t5_and");

        // 6: narrow instance multiply
        do_op(8, OP_MULU, 64'hFF, 64'h02, 0, "t6_mulu8");

        // randomized ops on both widths
        for (int i = 0; i < 30; i++) begin
            logic [2:0]  o;
            logic [63:0] x, y;
            int          pat;
            o   = 3'($urandom_range(0, 7));
            pat = $urandom_range(0, 3);
            x   = {32'h0, $urandom};
            y   = {32'h0, $urandom};
            if (pat == 1) y = 64'd0;
            if (pat == 2) y = x;
            if (pat == 3) begin x = x & 64'hFF; y = 64'($urandom_range(1, 15)); end
            do_op(32, o, x, y, 0, $sformatf("r32_%0d", i));
        end
        for (int i = 0; i < 20; i++) begin
            logic [2:0]  o;
            logic [63:0] x, y;
            o = 3'($urandom_range(0, 7));
            x = 64'($urandom_range(0, 255));
            y = ($urandom_range(0, 3) == 0) ? 64'd0 : 64'($urandom_range(0, 255));
            do_op(8, o, x, y, 0, $sformatf("r8_%0d", i));
        end

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered ALU for the next-generation datapath; replaces the purely combinational ALU.
- Keeps the single-cycle logic/arithmetic operations, now with a registered result.
- Adds iterative unsigned multiply and divide, with a start/busy/done handshake so the control unit can stall.
- Sits between the register-file read stage and the writeback mux.

Parameters:
- WIDTH, 32: operand/result width in bits (>=4).
- CNT_W, 6: iteration-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- op  input  3  operation code (see Behaviour).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when result/flags are valid.
- result  output  WIDTH  main result (product low half / quotient).
- result_hi  output  WIDTH  product high half / remainder; 0 for other ops.
- zero  output  1  result == 0.
- carryout  output  1  ADD: carry out; SUB: borrow (inverted carry); else 0.
- overflow  output  1  signed overflow for ADD/SUB; else 0.
- div_by_zero  output  1  DIVU with b==0; else 0.

Behaviour:
- Reset: state=IDLE; busy, done, result, result_hi, zero, carryout, overflow, div_by_zero all 0; counter 0.
- Op codes:
  - 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed), 101 SLTU, 011 MULU, 100 DIVU.
  - Unused codes: none; all 8 codes are defined.
- States: IDLE, MUL, DIV, FIN.
- IDLE + start with a single-cycle op (AND/OR/ADD/SUB/SLT/SLTU):
  - result and flags are registered on that edge; done=1 in the next cycle; stays in IDLE; busy stays 0.
  - Latency: 1 cycle.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - SUB computes a + ~b + 1; carryout = ~carry.
  - overflow = (sign a == sign b') && (sign sum != sign a), where b' is the effective operand after inversion.
  - SLT: result = {0..,N^V} of a-b. SLTU: result = {0..,borrow}.
- IDLE + start with MULU:
  - Latch a/b; accumulator=0; go to MUL; busy=1.
  - Radix-2 shift-add, one bit per cycle, for WIDTH cycles; then FIN.
  - FIN drives done=1, busy=0 and returns to IDLE.
  - result = product[WIDTH-1:0]; result_hi = product[2*WIDTH-1:WIDTH].
  - Latency from start edge to done: WIDTH+1 cycles.
- IDLE + start with DIVU, b != 0:
  - Restoring division, WIDTH iterations in DIV, then FIN; same latency as MULU.
  - result = quotient; result_hi = remainder.
- DIVU with b == 0:
  - No iteration; done on the next cycle (1-cycle latency).
  - result = all ones; result_hi = a; div_by_zero=1.
- Flags:
  - zero reflects result only (not result_hi), for every op.
  - For MULU/DIVU: carryout=0 and overflow=0.
- Output holding: outputs hold their last value until the next done; done is high for exactly one cycle per accepted start.
- Operand stability: a, b and op are latched at start; changes while busy have no effect.
- start while busy (MUL/DIV/FIN): ignored; no queueing; the current operation is unaffected.
- start in the same cycle done is asserted from a single-cycle op: accepted (back-to-back single-cycle ops give done every cycle).
- rst_n low mid-operation: immediate abort to the reset values; no done pulse is produced.

Test Plan:
1. ADD: a=0x7FFFFFFF, b=1, start -> next cycle done=1, result=0x80000000, overflow=1, carryout=0, zero=0, busy never 1.
2. SUB then SLT back-to-back:
   - Cycle 0: a=5, b=5, op=110 -> done, result=0, zero=1, carryout=0.
   - Cycle 1: a=0xFFFFFFFF, b=1, op=111 -> done, result=1.
   - Same operands with op=101 -> result=0.
3. MULU: a=0xFFFFFFFF, b=0xFFFFFFFF -> busy for 32 cycles, done at cycle 33, result=0x00000001, result_hi=0xFFFFFFFE. A start pulse at cycle 10 is ignored.
4. DIVU: a=100, b=7 -> done at cycle 33, result=14, result_hi=2, div_by_zero=0. Then a=9, b=0 -> done after 1 cycle, result=0xFFFFFFFF, result_hi=9, div_by_zero=1.
5. Reset abort: start MULU, assert rst_n=0 at cycle 15 -> busy=0, done=0, result=0 immediately. Release reset and issue AND a=0xF0F0, b=0xFF00 -> result=0xF000.
6. WIDTH=8 instance: MULU a=0xFF, b=0x02 -> done at cycle 9, result=0xFE, result_hi=0x01.
